// File: rtl/isqrt_pkg.sv
// Shared types and constants for the iterative integer square-root engine.
package isqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ODD  = 2'd1,
        BIT  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_ODD = 1'b0;
    localparam logic MODE_BIT = 1'b1;

    function automatic int calc_rw(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/isqrt_bit_step.sv
// One digit-by-digit restoring square-root step: brings in the next radicand
// bit pair and decides the next root bit.
module isqrt_bit_step #(
    parameter int RW = 8
) (
    input  logic [RW-1:0] r,
    input  logic [RW+1:0] a,
    input  logic [1:0]    pair,
    output logic [RW-1:0] r_next,
    output logic [RW+1:0] a_next
);

    logic [RW+1:0] t;
    logic [RW+1:0] trial;
    logic [RW:0]   r_shift;

    // The partial remainder never exceeds twice the partial root, so t fits
    // in RW+2 bits for every step of the loop.
    always_comb begin
        t     = (a << 2) | {{RW{1'b0}}, pair};
        trial = {r, 2'b01};
        if (t >= trial) begin
            a_next  = t - trial;
            r_shift = {r, 1'b1};
        end else begin
            a_next  = t;
            r_shift = {r, 1'b0};
        end
        r_next = r_shift[RW-1:0];
    end

endmodule

// File: rtl/isqrt_seq.sv
// Iterative integer square root with runtime choice of odd-number subtraction
// (latency root+2) or digit-by-digit restoring (latency RW+1).
module isqrt_seq
    import isqrt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         go,
    input  logic                         mode,
    input  logic [WIDTH-1:0]             din,
    output logic                         ready,
    output logic                         busy,
    output logic                         done,
    output logic [calc_rw(WIDTH)-1:0]    root,
    output logic [calc_rw(WIDTH):0]      rem
);

    localparam int RW = calc_rw(WIDTH);
    localparam int IW = (RW > 1) ? $clog2(RW) : 1;

    state_t state_q, state_d;

    logic [WIDTH-1:0] acc_q;
    logic [RW:0]      k_q;
    logic [RW-1:0]    cnt_q;
    logic [RW-1:0]    r_q;
    logic [RW+1:0]    a_q;
    logic [WIDTH-1:0] s_q;
    logic [IW-1:0]    i_q;
    logic [RW-1:0]    root_q;
    logic [RW:0]      rem_q;

    logic             odd_ge;
    logic [RW-1:0]    r_next;
    logic [RW+1:0]    a_next;

    assign odd_ge = (acc_q >= WIDTH'(k_q));

    isqrt_bit_step #(.RW(RW)) u_step (
        .r      (r_q),
        .a      (a_q),
        .pair   (s_q[WIDTH-1:WIDTH-2]),
        .r_next (r_next),
        .a_next (a_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (go) state_d = (mode == MODE_BIT) ? BIT : ODD;
            ODD:  if (!odd_ge) state_d = DONE;
            BIT:  if (i_q == '0) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE);
        busy  = (state_q == ODD) || (state_q == BIT);
        done  = (state_q == DONE);
        root  = root_q;
        rem   = rem_q;
    end

    // Both algorithms are initialised on capture so the loop never needs to
    // know which one was selected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            k_q    <= '0;
            cnt_q  <= '0;
            r_q    <= '0;
            a_q    <= '0;
            s_q    <= '0;
            i_q    <= '0;
            root_q <= '0;
            rem_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        acc_q <= din;
                        k_q   <= (RW+1)'(1);
                        cnt_q <= '0;
                        r_q   <= '0;
                        a_q   <= '0;
                        s_q   <= din;
                        i_q   <= IW'(RW - 1);
                    end
                end
                ODD: begin
                    if (odd_ge) begin
                        acc_q <= acc_q - WIDTH'(k_q);
                        k_q   <= k_q + (RW+1)'(2);
                        cnt_q <= cnt_q + RW'(1);
                    end else begin
                        root_q <= cnt_q;
                        rem_q  <= acc_q[RW:0];
                    end
                end
                BIT: begin
                    r_q <= r_next;
                    a_q <= a_next;
                    s_q <= s_q << 2;
                    if (i_q == '0) begin
                        root_q <= r_next;
                        rem_q  <= a_next[RW:0];
                    end else begin
                        i_q <= i_q - IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/isqrt_seq.md
Name: isqrt_seq

Overview:
Parametrised iterative integer square-root engine. It replaces the fixed 9-bit odd-number-subtraction datapath/controller pair with one self-contained block. It supports any even operand width and two runtime-selectable algorithms: odd-subtraction (variable latency) and digit-by-digit restoring (fixed latency). It returns both root and remainder through a ready/busy/done handshake, for use beside the ALU on the breadboard bus.

Parameters:
WIDTH, 16, operand width in bits; must be even and >= 2.
RW, WIDTH/2, root width; derived, not overridable.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
go  input  1  start request, sampled on rising clk edge only while ready=1
mode  input  1  algorithm select, captured with go: 0 = odd-subtraction, 1 = digit-by-digit
din  input  WIDTH  radicand, captured with go
ready  output  1  high in IDLE; go is accepted only when high
busy  output  1  high while iterating
done  output  1  one-cycle pulse when root/rem become valid
root  output  RW  floor(sqrt(din))
rem  output  RW+1  din - root*root; maximum 2*root

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ready=1, busy=0, done=0, root=0, rem=0. All internal registers clear. Takes effect immediately, including mid-operation. The in-flight result is discarded and no done pulse is issued.
- States: IDLE, ODD, BIT, DONE.
- IDLE behaviour:
  - If go=1 at an edge, latch din and mode, then go to ODD (mode=0) or BIT (mode=1). busy=1 and ready=0 from the next cycle.
  - Otherwise stay in IDLE.
- ODD state:
  - Init on capture: acc=din (WIDTH bits), k=1 (RW+1 bits), cnt=0 (RW bits).
  - Each cycle: if acc >= k, then acc -= k, k += 2, cnt += 1, and stay in ODD.
  - Otherwise load root=cnt and rem=acc[RW:0], then go to DONE.
  - The loop runs root+1 cycles.
- BIT state:
  - Init on capture: r=0 (RW bits), a=0 (RW+2 bits), shift register s=din, step counter i=RW-1.
  - Each cycle: t = (a<<2) | s[WIDTH-1:WIDTH-2] and trial = (r<<2) | 1.
  - If t >= trial, then a = t - trial and r = (r<<1) | 1. Otherwise a = t and r = r<<1.
  - Then s <<= 2.
  - When i=0, load root and rem from the updated values and go to DONE. Otherwise decrement i.
  - The loop runs exactly RW cycles.
- DONE state: lasts one cycle with done=1, busy=0, ready=0, then returns to IDLE.
- Latency, counted from the capture edge to the edge at which done is first seen high:
  - mode 0: root+2 cycles.
  - mode 1: RW+1 cycles.
- Output holding: root and rem update only at the transition into DONE. They hold until the next completion or reset and do not change during a new computation.
- go while busy or in DONE: ignored. It is neither queued nor restarting. din and mode changes after capture have no effect.
- Width rules:
  - All compares are unsigned.
  - ODD-mode compares zero-extend k to WIDTH.
  - k never exceeds 2^(RW+1)-1; cnt never exceeds 2^RW-1.
  - No wrap-around may occur for any din.
- Boundaries:
  - din=0 gives root=0, rem=0.
  - din=2^WIDTH-1 gives root=2^RW-1, rem=2^(RW+1)-2.
  - Perfect squares give rem=0.

Decomposition:
- Package isqrt_pkg holds:
  - state enum (IDLE, ODD, BIT, DONE);
  - mode constants MODE_ODD=0 and MODE_BIT=1;
  - a function computing RW from WIDTH.
- One combinational sub-module, isqrt_bit_step, parametrised by RW:
  - inputs r, a, and a two-bit pair;
  - outputs next r and next a;
  - it isolates the BIT-mode datapath so it can be unit-tested exhaustively for small RW.

Test Plan:
- WIDTH=16, din=64, mode=0, go pulse -> root=8, rem=0, done pulse 10 cycles after capture, busy high for 9 cycles.
- WIDTH=16, din=64, mode=1 -> root=8, rem=0, done 9 cycles after capture. Repeat with din=65535 in both modes -> root=255, rem=510, mode-0 done after 257 cycles.
- din=0 in mode 0 -> root=0, rem=0, done after 2 cycles. din=99 in mode 1 -> root=9, rem=18.
- Start din=200 mode 0; at cycle 3 pulse go with din=4 -> the second go is ignored, result root=14, rem=4. Then go in IDLE with din=4 -> root=2, rem=0.
- Start din=1000 mode 1; drive reset low mid-iteration (between clock edges) -> outputs clear immediately, ready=1, and no done pulse. After release, new go with din=1000 -> root=31, rem=39.
- WIDTH=4 build: exhaustive din 0..15 in both modes -> every root/rem pair matches a reference model, and latency is exact per the formula.
